// File: rtl/pc_adder_if.sv
// Operand/result bundle for the registered PC adder.
// master drives operands, slave returns the registered result and flags.
interface pc_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] IN1;
    logic [WIDTH-1:0] IN2;
    logic             Sub;
    logic             InValid;
    logic [WIDTH-1:0] OUT;
    logic             OutValid;
    logic             CarryOut;
    logic             Overflow;
    logic             Zero;

    modport master (
        output IN1, IN2, Sub, InValid,
        input  OUT, OutValid, CarryOut, Overflow, Zero
    );

    modport slave (
        input  IN1, IN2, Sub, InValid,
        output OUT, OutValid, CarryOut, Overflow, Zero
    );
endinterface

// File: rtl/pc_adder.sv
// Registered two-operand add/subtract unit, one result per cycle.
// Used for PC+4 and branch-target computation, with valid and status flags.
module pc_adder #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic       Clk,
    input logic       Rst_n,
    pc_adder_if.slave bus
);
    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    logic [WIDTH-1:0] out_d, out_q;
    logic             valid_d, valid_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    // Subtract as A + ~B + 1, so CarryOut reads as not-borrow.
    always_comb begin
        b_eff = bus.Sub ? ~bus.IN2 : bus.IN2;
        sum   = {1'b0, bus.IN1}
              + {1'b0, b_eff}
              + {{WIDTH{1'b0}}, bus.Sub};
    end

    // Operands are only looked at when InValid is high, so X inputs
    // during idle cycles never reach the held state.
    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        if (bus.InValid) begin
            out_d   = sum[MSB:0];
            carry_d = sum[WIDTH];
            ovf_d   = (bus.IN1[MSB] == b_eff[MSB])
                   && (sum[MSB] != bus.IN1[MSB]);
            zero_d  = (sum[MSB:0] == '0);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_q   <= RESET_VALUE;
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= (RESET_VALUE == '0);
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.OUT      = out_q;
    assign bus.OutValid = valid_q;
    assign bus.CarryOut = carry_q;
    assign bus.Overflow = ovf_q;
    assign bus.Zero     = zero_q;
endmodule

// File: tb/tb_pc_adder.sv
// Directed and reference-model checks for pc_adder.
// Expected word packs {OUT, OutValid, CarryOut, Overflow, Zero}.
module tb_pc_adder;
    logic Clk;
    logic Rst_n;
    int   tests;
    int   failed;

    pc_adder_if #(.WIDTH(32)) bus ();

    pc_adder #(
        .WIDTH(32),
        .RESET_VALUE(32'h0)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [35:0] pk(
        input logic [31:0] o, input logic v,
        input logic c, input logic ov, input logic z);
        return {o, v, c, ov, z};
    endfunction

    task automatic chk(input string tag, input logic [35:0] exp);
        logic [35:0] obs;
        obs = {bus.OUT, bus.OutValid, bus.CarryOut,
               bus.Overflow, bus.Zero};
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic iv);
        bus.IN1     = a;
        bus.IN2     = b;
        bus.Sub     = s;
        bus.InValid = iv;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] e_out;
    logic        e_v, e_c, e_o, e_z;
    logic [31:0] ra, rb;
    logic        rs, riv;
    longint      sr;

    initial begin
        tests  = 0;
        failed = 0;
        Rst_n  = 1'b0;
        drive(32'h100, 32'd4, 1'b0, 1'b1);
        step();
        step();
        chk("reset_hold", pk(32'h0, 0, 0, 0, 1));

        Rst_n = 1'b1;
        step();
        chk("reset_release", pk(32'h104, 1, 0, 0, 0));

        drive(32'h0, 32'd4, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("pc_inc_%0d", i),
                pk(32'(4 * i), 1, 0, 0, 0));
            bus.IN1 = bus.OUT;
        end

        drive(32'hFFFF_FFFC, 32'd4, 1'b0, 1'b1);
        step();
        chk("wrap", pk(32'h0, 1, 1, 0, 1));

        drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        step();
        chk("sovf_add", pk(32'h8000_0000, 1, 0, 1, 0));

        drive(32'h7FFF_FFFC, 32'd4, 1'b0, 1'b1);
        step();
        chk("sovf_pc", pk(32'h8000_0000, 1, 0, 1, 0));

        drive(32'd5, 32'd7, 1'b1, 1'b1);
        step();
        chk("sub_5_7", pk(32'hFFFF_FFFE, 1, 0, 0, 0));

        drive(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        step();
        chk("sovf_sub", pk(32'h7FFF_FFFF, 1, 1, 1, 0));

        drive(32'h1234, 32'h1234, 1'b1, 1'b1);
        step();
        chk("sub_self", pk(32'h0, 1, 1, 0, 1));

        drive(32'h0, 32'h1, 1'b1, 1'b1);
        step();
        chk("sub_0_1", pk(32'hFFFF_FFFF, 1, 0, 0, 0));

        drive(32'd10, 32'd20, 1'b0, 1'b1);
        step();
        chk("hold_load", pk(32'd30, 1, 0, 0, 0));
        drive(32'd99, 32'hx, 1'bx, 1'b0);
        step();
        chk("hold_1", pk(32'd30, 0, 0, 0, 0));
        step();
        chk("hold_2", pk(32'd30, 0, 0, 0, 0));

        drive(32'h40, 32'd4, 1'b0, 1'b1);
        step();
        chk("pre_async", pk(32'h44, 1, 0, 0, 0));
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst", pk(32'h0, 0, 0, 0, 1));
        step();
        chk("async_hold", pk(32'h0, 0, 0, 0, 1));
        Rst_n = 1'b1;

        e_out = 32'h0;
        e_v   = 1'b0;
        e_c   = 1'b0;
        e_o   = 1'b0;
        e_z   = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd4 : $urandom;
            rs  = 1'($urandom_range(0, 1));
            riv = ($urandom_range(0, 4) != 0);
            if (n % 50 == 7)
                rb = ra;
            if (riv) begin
                drive(ra, rb, rs, 1'b1);
                if (rs) begin
                    e_out = ra - rb;
                    e_c   = (ra >= rb);
                    sr    = longint'($signed(ra))
                          - longint'($signed(rb));
                end else begin
                    e_out = ra + rb;
                    e_c   = ((33'(ra) + 33'(rb)) > 33'hFFFF_FFFF);
                    sr    = longint'($signed(ra))
                          + longint'($signed(rb));
                end
                e_o = (sr > 64'sd2147483647)
                   || (sr < -64'sd2147483648);
                e_z = (e_out == 32'h0);
                e_v = 1'b1;
            end else begin
                drive(32'hx, 32'hx, 1'bx, 1'b0);
                e_v = 1'b0;
            end
            step();
            chk($sformatf("rand_%0d", n),
                pk(e_out, e_v, e_c, e_o, e_z));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/pc_adder.md
Name: pc_adder

Overview:
- Registered 32-bit two-operand adder. Primary use is the PC-increment path: IN1 = current PC, IN2 = constant 4, OUT = next sequential PC.
- Also usable as a general add/subtract unit (branch-target computation).
- One result per clock, latency 1 cycle, with valid tagging and status flags.

Parameters:
- WIDTH, 32, operand and result width in bits.
- RESET_VALUE, 0, value OUT holds during and after reset.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- IN1  input  WIDTH  operand A, for example the current PC.
- IN2  input  WIDTH  operand B, for example the constant 4.
- Sub  input  1  0 = add (A+B), 1 = subtract (A-B).
- InValid  input  1  operands and Sub are valid this cycle.
- OUT  output  WIDTH  registered result.
- OutValid  output  1  OUT holds a result computed from a valid input.
- CarryOut  output  1  carry out of the MSB (add); not-borrow (sub).
- Overflow  output  1  two's-complement signed overflow.
- Zero  output  1  OUT == 0.

Behaviour:
- Reset:
  - Rst_n low asynchronously forces OUT = RESET_VALUE, OutValid = 0, CarryOut = 0, Overflow = 0, Zero = (RESET_VALUE == 0).
  - Outputs hold these values while Rst_n is low.
  - Release is synchronous to the next rising Clk. The first sample is taken at the first rising edge with Rst_n high.
- Arithmetic, on each rising Clk with InValid = 1:
  - Compute {c, s} = A + (Sub ? ~B : B) + Sub, in WIDTH+1 bits.
  - OUT <= s (modulo 2^WIDTH).
  - CarryOut <= c.
  - Overflow <= (A[MSB] == B'[MSB]) && (s[MSB] != A[MSB]), where B' is the inverted-or-not operand.
  - Zero <= (s == 0).
  - OutValid <= 1.
- Hold: with InValid = 0, OUT, CarryOut, Overflow and Zero hold their previous values, and OutValid <= 0.
- Latency: exactly 1 cycle from an InValid sample to OutValid/OUT. Throughput is one operation per cycle, back-to-back, with no stall or backpressure.
- Wrap-around: 0xFFFFFFFC + 4 gives OUT = 0x00000000, CarryOut = 1, Zero = 1, Overflow = 0. No saturation.
- Signed overflow: 0x7FFFFFFC + 4 gives OUT = 0x80000000, Overflow = 1, CarryOut = 0.
- Subtract: A - A gives Zero = 1, CarryOut = 1. 0 - 1 gives 0xFFFFFFFF, CarryOut = 0.
- Reset mid-operation: a result in flight is discarded, and outputs go to reset values immediately (combinationally from Rst_n).
- Inputs with X/Z while InValid = 0 must not disturb the held outputs.
- No combinational path from inputs to outputs, except Rst_n to the registers.

Test Plan:
- Reset: hold Rst_n = 0 with IN1 = 0x100, IN2 = 4, InValid = 1 -> OUT = 0, OutValid = 0. Release -> next edge OUT = 0x104, OutValid = 1.
- PC increment sequence: IN2 = 4, IN1 fed back from OUT each cycle starting at 0, InValid = 1 -> OUT = 4, 8, 12, 16 on successive edges, CarryOut = 0, Overflow = 0.
- Unsigned wrap: IN1 = 0xFFFFFFFC, IN2 = 4, Sub = 0 -> OUT = 0, CarryOut = 1, Zero = 1, Overflow = 0.
- Signed overflow and subtract:
  - 0x7FFFFFFF + 1 -> OUT = 0x80000000, Overflow = 1.
  - Sub = 1, 5 - 7 -> OUT = 0xFFFFFFFE, CarryOut = 0, Overflow = 0.
  - 0x80000000 - 1 -> Overflow = 1.
- Hold/valid: InValid = 1 for (10 + 20), then InValid = 0 with IN1 = 99 -> OUT stays 30, OutValid falls to 0 after one cycle.
- Async reset mid-stream: assert Rst_n low between clock edges while OutValid = 1 -> OUT = 0 and OutValid = 0 immediately, without waiting for Clk. Check against a randomized reference model of 1000 vectors after release.
